// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      S_ASSERT  = 2'd0,
      S_HOLD    = 2'd1,
      S_RELEASE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   // Counter must reach max(hold, gap) - 1 and reloads at terminal count.
   function automatic int cnt_width(input int hold, input int gap);
      int m;
      m = (hold > gap) ? hold : gap;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_sync_chain.sv
// Multi-flop synchroniser; reset clears every stage to 0 (request active).
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stages_q;
   logic [STAGES-1:0] stages_d;

   always_comb begin
      stages_d = {stages_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stages_q <= '0;
      end else begin
         stages_q <= stages_d;
      end
   end

   assign q = stages_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Merges a synchronised external reset request with a software pulse and
// releases NUM_CH active-low channel resets in order after a hold time.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_rst_req_n,
   input  logic              sw_rst_req,
   output logic [NUM_CH-1:0] rst_out_n,
   output logic              rst_done
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int IDX_W = $clog2(NUM_CH + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_CH-1:0]   rst_out_n_q, rst_out_n_d;
   logic                rst_done_q, rst_done_d;
   logic                req_sync;
   logic                req_active;

   sync_chain #(.STAGES(SYNC_STAGES)) u_ext_sync (
      .clk (clk),
      .rst (rst),
      .d   (ext_rst_req_n),
      .q   (req_sync)
   );

   assign req_active = ~req_sync | sw_rst_req;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_out_n_d = rst_out_n_q;
      rst_done_d  = rst_done_q;

      // Any live request wins over sequencing, whatever the state.
      if (req_active) begin
         state_d     = S_ASSERT;
         cnt_d       = '0;
         idx_d       = '0;
         rst_out_n_d = '0;
         rst_done_d  = 1'b0;
      end else begin
         case (state_q)
            S_ASSERT: begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_out_n_d[0] = 1'b1;
                  cnt_d          = '0;
                  if (NUM_CH == 1) begin
                     rst_done_d = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     idx_d   = IDX_W'(1);
                     state_d = S_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (idx_q == IDX_W'(i)) rst_out_n_d[i] = 1'b1;
                  end
                  cnt_d = '0;
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) begin
                     rst_done_d = 1'b1;
                     state_d    = S_DONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
            end
            default: begin
               state_d = S_ASSERT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ASSERT;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_out_n_q <= '0;
         rst_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_out_n_q <= rst_out_n_d;
         rst_done_q  <= rst_done_d;
      end
   end

   assign rst_out_n = rst_out_n_q;
   assign rst_done  = rst_done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Cycle-by-cycle vector bench for rst_sequencer: default build plus a
// single-channel, one-cycle-hold build sharing the same stimulus.
module tb_rst_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_n;
   logic       sw;
   logic [2:0] a_out;
   logic       a_done;
   logic [0:0] b_out;
   logic       b_done;

   always #5 clk = ~clk;

   rst_sequencer #(
      .NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .GAP_CYCLES(3)
   ) u_dut_a (
      .clk(clk), .rst(rst), .ext_rst_req_n(ext_n), .sw_rst_req(sw),
      .rst_out_n(a_out), .rst_done(a_done)
   );

   rst_sequencer #(
      .NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(3)
   ) u_dut_b (
      .clk(clk), .rst(rst), .ext_rst_req_n(ext_n), .sw_rst_req(sw),
      .rst_out_n(b_out), .rst_done(b_done)
   );

   typedef struct {
      logic       rst;
      logic       ext_n;
      logic       sw;
      logic [2:0] a_out;
      logic       a_done;
      logic       chk_b;
      logic       b_out;
      logic       b_done;
      string      tag;
   } vec_t;

   vec_t  vecs[$];
   vec_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   string tag;

   task automatic add(input logic r, input logic e, input logic s, input int n,
                      input logic [2:0] ao, input logic ad,
                      input logic cb, input logic bo, input logic bd);
      vec_t v;
      v.rst = r; v.ext_n = e; v.sw = s;
      v.a_out = ao; v.a_done = ad;
      v.chk_b = cb; v.b_out = bo; v.b_done = bd;
      v.tag = tag;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic seg(input logic r, input logic e, input logic s, input int n,
                      input logic [2:0] ao, input logic ad);
      add(r, e, s, n, ao, ad, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; ext_n = 1'b1; sw = 1'b0;

      // Power-up; the single-channel build is checked alongside.
      tag = "powerup";
      add(1, 1, 0, 3, 3'b000, 0, 1, 0, 0);
      add(0, 1, 0, 3, 3'b000, 0, 1, 0, 0);   // E1-E3, B in HOLD at E3
      add(0, 1, 0, 3, 3'b000, 0, 1, 1, 1);   // E4-E6, B done at E4
      add(0, 1, 0, 3, 3'b001, 0, 1, 1, 1);   // E7-E9
      add(0, 1, 0, 3, 3'b011, 0, 1, 1, 1);   // E10-E12
      add(0, 1, 0, 3, 3'b111, 1, 1, 1, 1);   // E13-E15

      // Software pulse on the edge the synchroniser first reads inactive.
      tag = "sw_at_sync_release";
      seg(1, 1, 0, 2, 3'b000, 0);
      seg(0, 1, 0, 2, 3'b000, 0);            // E1-E2
      seg(0, 1, 1, 1, 3'b000, 0);            // E3 held in ASSERT
      seg(0, 1, 0, 4, 3'b000, 0);            // E4 HOLD entry .. E7
      seg(0, 1, 0, 3, 3'b001, 0);            // E8-E10
      seg(0, 1, 0, 1, 3'b011, 0);            // E11

      // External request mid-release.
      tag = "ext_mid_release";
      seg(1, 1, 0, 2, 3'b000, 0);
      seg(0, 1, 0, 6, 3'b000, 0);            // E1-E6
      seg(0, 1, 0, 3, 3'b001, 0);            // E7-E9
      seg(0, 1, 0, 2, 3'b011, 0);            // E10-E11
      seg(0, 0, 0, 1, 3'b011, 0);            // E12
      seg(0, 0, 0, 1, 3'b111, 1);            // E13, request still in sync chain
      seg(0, 0, 0, 1, 3'b000, 0);            // E14
      seg(0, 1, 0, 6, 3'b000, 0);            // E15-E20, HOLD re-entry at E17
      seg(0, 1, 0, 3, 3'b001, 0);            // E21-E23
      seg(0, 1, 0, 3, 3'b011, 0);            // E24-E26
      seg(0, 1, 0, 2, 3'b111, 1);            // E27-E28

      // Software reset from DONE.
      tag = "sw_in_done";
      seg(1, 1, 0, 2, 3'b000, 0);
      seg(0, 1, 0, 6, 3'b000, 0);
      seg(0, 1, 0, 3, 3'b001, 0);
      seg(0, 1, 0, 3, 3'b011, 0);
      seg(0, 1, 0, 7, 3'b111, 1);            // E13-E19
      seg(0, 1, 1, 1, 3'b000, 0);            // E20
      seg(0, 1, 0, 4, 3'b000, 0);            // E21-E24
      seg(0, 1, 0, 3, 3'b001, 0);            // E25-E27
      seg(0, 1, 0, 3, 3'b011, 0);            // E28-E30
      seg(0, 1, 0, 2, 3'b111, 1);            // E31-E32

      // Block reset mid-HOLD.
      tag = "rst_mid_hold";
      seg(1, 1, 0, 2, 3'b000, 0);
      seg(0, 1, 0, 4, 3'b000, 0);            // E1-E4
      seg(1, 1, 0, 3, 3'b000, 0);            // E5-E7
      seg(0, 1, 0, 6, 3'b000, 0);            // E8-E13, HOLD at E10
      seg(0, 1, 0, 3, 3'b001, 0);            // E14-E16
      seg(0, 1, 0, 3, 3'b011, 0);            // E17-E19
      seg(0, 1, 0, 2, 3'b111, 1);            // E20-E21

      // Long external request, then release.
      tag = "ext_long";
      seg(1, 1, 0, 2, 3'b000, 0);
      seg(0, 0, 0, 100, 3'b000, 0);          // E1-E100
      seg(0, 1, 0, 6, 3'b000, 0);            // E101-E106, HOLD at E103
      seg(0, 1, 0, 1, 3'b001, 0);            // E107

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         rst   = vecs[k].rst;
         ext_n = vecs[k].ext_n;
         sw    = vecs[k].sw;
         exp_q.push_back(vecs[k]);
         @(posedge clk);
         #1;
         v = exp_q.pop_front();
         checks++;
         if ({a_out, a_done} !== {v.a_out, v.a_done}) begin
            failures++;
            $display("FAIL %s step=%0d a: got out=%b done=%b want out=%b done=%b",
                     v.tag, k, a_out, a_done, v.a_out, v.a_done);
         end
         if (v.chk_b) begin
            checks++;
            if ({b_out, b_done} !== {v.b_out, v.b_done}) begin
               failures++;
               $display("FAIL %s step=%0d b: got out=%b done=%b want out=%b done=%b",
                        v.tag, k, b_out, b_done, v.b_out, v.b_done);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
